// File: rtl/kreacher_pipe_pkg.sv
// Shared definitions for the kreacher pipeline buffers.
//   - ST_EMPTY / ST_ONE / ST_FULL : occupancy-coded state of a two-entry skid buffer
//   - DEF_DATA_W / DEF_TAG_W      : default payload and sideband widths
package kreacher_pipe_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_TAG_W  = 5;

  // The encoding equals the number of held entries, so the state doubles as occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/reg_en_sr.sv
// Parameterised register with synchronous active-high reset and load enable.
//   clk : clock, rising edge
//   rst : synchronous reset, clears q to zero
//   en  : load enable, q <= d when high
//   d   : next value
//   q   : registered value
module reg_en_sr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of process evaluation order.
  // NOTE: the storage is cleared on reset because the buffer must present
  // out_data = 0 after reset, not just a don't-care value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/skid_buffer_64bit.sv
// Two-entry elastic (skid) buffer between operand select and execute.
// in_ready depends only on local state, flush and rst, never on out_ready,
// which breaks the combinational ready path from execute back upstream.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, empties buffer and zeroes storage
//   flush     : synchronous discard of all buffered entries
//   in_data   : payload offered by upstream
//   in_tag    : tag (destination register index) travelling with in_data
//   in_valid  : upstream offers in_data/in_tag
//   in_ready  : buffer accepts this cycle
//   out_data  : oldest buffered payload
//   out_tag   : tag of oldest entry
//   out_valid : out_data/out_tag valid
//   out_ready : downstream consumes this cycle
//   occupancy : entries held (0..2)
module skid_buffer_64bit
  import kreacher_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  localparam int ENT_W = TAG_W + DATA_W;

  buf_state_e state, state_next;

  logic             acc;
  logic             deq;
  logic             main_load;
  logic             main_from_skid;
  logic             skid_load;
  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] main_d;
  logic [ENT_W-1:0] main_q;
  logic [ENT_W-1:0] skid_q;

  assign in_ent    = {in_tag, in_data};
  assign in_ready  = (state != ST_FULL) && !flush && !rst;
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q[DATA_W-1:0];
  assign out_tag   = main_q[ENT_W-1:DATA_W];
  assign occupancy = state;

  assign acc = in_valid && in_ready;
  assign deq = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;

    unique case (state)
      ST_EMPTY: begin
        if (acc) begin
          state_next = ST_ONE;
          main_load  = 1'b1;
        end
      end
      ST_ONE: begin
        if (acc && deq) begin
          main_load = 1'b1;
        end else if (acc) begin
          state_next = ST_FULL;
          skid_load  = 1'b1;
        end else if (deq) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // The skid entry is younger than main, so it moves up on dequeue.
        if (deq) begin
          state_next     = ST_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase

    // Flush overrides every transition; data registers are left untouched.
    if (flush) begin
      state_next     = ST_EMPTY;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_ent;

  reg_en_sr #(.W(ENT_W)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_load),
    .d   (main_d),
    .q   (main_q)
  );

  reg_en_sr #(.W(ENT_W)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_load),
    .d   (in_ent),
    .q   (skid_q)
  );

endmodule

// File: tb/tb_skid_buffer_64bit.sv
// Self-checking bench for skid_buffer_64bit: directed scenarios followed by
// random stall/flush traffic, all checked by a queue-based scoreboard.
module tb_skid_buffer_64bit;

  localparam int DATA_W = 64;
  localparam int TAG_W  = 5;

  typedef logic [TAG_W+DATA_W-1:0] ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [DATA_W-1:0] in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        occupancy;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  // Expected buffer contents, oldest first; the buffer holds at most two.
  ent_t              exp_q[$];
  logic [DATA_W-1:0] out_log[$];
  logic              exp_ready;

  skid_buffer_64bit #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare DUT against the expected queue between edges, then
  // apply what the upcoming edge will do (inputs are stable until then).
  always @(negedge clk) begin
    if (mon_en) begin
      exp_ready = (exp_q.size() < 2) && !flush && !rst;
      check("in_ready", in_ready, exp_ready);
      check("out_valid", out_valid, exp_q.size() != 0);
      check("occupancy", occupancy, exp_q.size());
      if (exp_q.size() != 0) begin
        check("out_data", out_data, exp_q[0][DATA_W-1:0]);
        check("out_tag", out_tag, exp_q[0][TAG_W+DATA_W-1:DATA_W]);
      end
      if (rst || flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) out_log.push_back(out_data);
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && exp_ready) exp_q.push_back({in_tag, in_data});
      end
    end
  end

  initial begin
    logic hold;
    rst       = 1'b1;
    flush     = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset for two edges, then a single pass-through word.
    step();
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    step();
    rst       = 1'b0;
    in_data   = 64'hDEAD_BEEF_0000_0001;
    in_tag    = 5'd3;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_out_data", out_data, 0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("pass_valid", out_valid, 1);
    check("pass_data", out_data, 64'hDEAD_BEEF_0000_0001);
    check("pass_tag", out_tag, 3);
    check("pass_occ", occupancy, 1);
    step();

    // Back-pressure fill: A, B stored, C held until space frees.
    out_log.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h1;
    in_tag    = 5'd1;
    step();
    in_data = 64'h2;
    in_tag  = 5'd2;
    step();
    in_data = 64'h3;
    in_tag  = 5'd4;
    @(negedge clk);
    check("bp_full_ready", in_ready, 0);
    check("bp_full_occ", occupancy, 2);
    step();
    step();
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    step();
    step();
    check("bp_count", out_log.size(), 3);
    for (int i = 0; i < 3 && i < out_log.size(); i++) check("bp_order", out_log[i], 64'(i + 1));

    // Full throughput: 16 back-to-back words.
    out_log.delete();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      in_tag   = 5'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("thru_count", out_log.size(), 16);
    for (int i = 0; i < 16 && i < out_log.size(); i++) check("thru_order", out_log[i], 64'(i));

    // Flush while full; the word offered during flush must be dropped.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA;
    step();
    in_data = 64'hB;
    step();
    flush   = 1'b1;
    in_data = 64'h4;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_occ", occupancy, 0);
    out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("flush_stays_empty", out_valid, 0);

    // Reset mid-operation with two entries held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h11;
    step();
    in_data = 64'h12;
    step();
    in_valid  = 1'b0;
    rst       = 1'b1;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_data", out_data, 0);
    check("mrst_occ", occupancy, 0);
    out_log.delete();
    step();
    step();
    step();
    check("mrst_no_stale", out_log.size(), 0);

    // Random traffic; upstream holds its offer until it is taken.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      hold = in_valid && !in_ready;
      step();
      if (!hold) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = {$urandom, $urandom};
        in_tag   = 5'($urandom_range(0, 31));
      end
      out_ready = $urandom_range(0, 1) != 0;
      flush     = ($urandom_range(0, 99) == 0);
    end

    // Drain and confirm nothing remains.
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
    @(negedge clk);
    check("drain_occ", occupancy, 0);
    check("drain_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
